// File: rtl/sprite_scheduler.sv
// Per-scanline sprite sequencer: walks sprite slots on each line pulse and
// issues one registered linebuffer draw step per cycle for each visible sprite.
`default_nettype none

module sprite_scheduler #(
    parameter int              IDX_W       = 9,
    parameter int              LB_AW       = 12,
    parameter int              WW          = 8,
    parameter int              WIDTH_SHIFT = 1,
    parameter int              XW          = 11,
    parameter int              LANES       = 8,
    parameter logic [LB_AW-1:0] OFF_SCREEN = 12'hff8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_i,
    input  logic [IDX_W:0]     sprite_count_i,
    input  logic [LB_AW-1:0]   lb_addr_i,
    input  logic [WW-1:0]      sprite_width_i,
    input  logic               sprite_skip_i,
    input  logic               sprite_ready_i,
    input  logic               pipe_stall_i,
    output logic [IDX_W-1:0]   sprite_index_o,
    output logic               sprite_valid_o,
    output logic [LB_AW-1:0]   lb_x_o,
    output logic [XW-1:0]      sprite_x_o,
    output logic               line_done_o,
    output logic               line_overrun_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             valid_q, valid_d;
    logic [LB_AW-1:0] lb_x_q, lb_x_d;
    logic [XW-1:0]    sx_q, sx_d;
    logic [XW-1:0]    end_q, end_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic [IDX_W:0]   cnt_eff;
    logic             is_last;
    logic             advance;
    logic [XW-1:0]    end_calc;

    assign cnt_eff  = (sprite_count_i > CNT_MAX) ? CNT_MAX : sprite_count_i;
    assign is_last  = ({1'b0, index_q} == (cnt_eff - (IDX_W+1)'(1)));
    assign end_calc = (XW'(sprite_width_i) << WIDTH_SHIFT) - XW'(1);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        valid_d   = valid_q;
        lb_x_d    = lb_x_q;
        sx_d      = sx_q;
        end_d     = end_q;
        done_d    = done_q;
        overrun_d = 1'b0;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                valid_d = 1'b0;
                lb_x_d  = OFF_SCREEN;
                if (cnt_eff == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (sprite_ready_i) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (sprite_skip_i || (sprite_width_i == '0)) begin
                    advance = 1'b1;
                end else begin
                    state_d = S_DRAW;
                    valid_d = 1'b1;
                    lb_x_d  = lb_addr_i;
                    sx_d    = '0;
                    end_d   = end_calc;
                end
            end
            S_DRAW: begin
                if (!pipe_stall_i) begin
                    lb_x_d = lb_x_q + LB_AW'(LANES);
                    sx_d   = sx_q + XW'(1);
                    // The step after the last pixel is a flush step, not a pixel.
                    if (sx_q == end_q) begin
                        valid_d = 1'b0;
                        advance = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                lb_x_d  = OFF_SCREEN;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (is_last) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                index_d = index_q + IDX_W'(1);
                state_d = S_LOAD;
            end
        end

        if (line_i) begin
            overrun_d = (state_q == S_LOAD) || (state_q == S_LATCH) || (state_q == S_DRAW);
            state_d   = S_LOAD;
            index_d   = '0;
            valid_d   = 1'b0;
            lb_x_d    = OFF_SCREEN;
            sx_d      = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            valid_q   <= 1'b0;
            lb_x_q    <= OFF_SCREEN;
            sx_q      <= '0;
            end_q     <= '0;
            done_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            lb_x_q    <= lb_x_d;
            sx_q      <= sx_d;
            end_q     <= end_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign sprite_index_o = index_q;
    assign sprite_valid_o = valid_q;
    assign lb_x_o         = lb_x_q;
    assign sprite_x_o     = sx_q;
    assign line_done_o    = done_q;
    assign line_overrun_o = overrun_q;

endmodule

`default_nettype wire
